// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter controller: FSM state
// encoding and the default parameter values used by pc_ctrl.
package pc_pkg;

  // Two-bit control state; the encoding is fixed here so every user agrees.
  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_STEP   = 2'b10
  } pc_state_e;

  localparam int unsigned PC_SZ_DEF    = 32'd32;
  localparam int unsigned PC_INC_DEF   = 32'd4;
  localparam int unsigned RESET_PC_DEF = 32'd0;
  localparam int unsigned CNT_SZ_DEF   = 32'd32;

  // True in the states where the fetch stream is allowed to move.
  function automatic logic state_active(input pc_state_e st);
    logic act;
    case (st)
      ST_RUN:  act = 1'b1;
      ST_STEP: act = 1'b1;
      default: act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program-counter storage: a load-enabled register with synchronous reset.
module pc_reg #(
  parameter int unsigned      PC_SZ    = 32'd32,
  parameter logic [PC_SZ-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PC_SZ-1:0] d,
  output logic [PC_SZ-1:0] q
);

  logic [PC_SZ-1:0] pc_r;

  // Hold the PC, replacing it only when the controller says it advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else if (load) begin
      pc_r <= d;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign q = pc_r;

endmodule

// File: rtl/pc_ctrl.sv
// Program-counter controller: RUN/HALTED/STEP debug FSM, next-PC selection
// (redirect beats stall), and a counter of PC advances since reset.
module pc_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned      PC_SZ    = PC_SZ_DEF,
  parameter int unsigned      PC_INC   = PC_INC_DEF,
  parameter logic [PC_SZ-1:0] RESET_PC = PC_SZ'(RESET_PC_DEF),
  parameter int unsigned      CNT_SZ   = CNT_SZ_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [PC_SZ-1:0]  i_target,
  input  logic              i_halt,
  input  logic              i_step,
  input  logic              i_resume,
  output logic [PC_SZ-1:0]  o_pc,
  output logic [PC_SZ-1:0]  o_pc_next,
  output logic              o_valid,
  output logic              o_halted,
  output logic [CNT_SZ-1:0] o_fetch_cnt
);

  localparam logic [PC_SZ-1:0]  PC_INC_V = PC_SZ'(PC_INC);
  localparam logic [CNT_SZ-1:0] CNT_ONE  = {{(CNT_SZ-1){1'b0}}, 1'b1};

  pc_state_e         state_r;
  pc_state_e         state_next_s;
  logic              halted_r;
  logic [CNT_SZ-1:0] cnt_r;
  logic [PC_SZ-1:0]  pc_s;
  logic [PC_SZ-1:0]  pc_seq_s;
  logic [PC_SZ-1:0]  pc_load_s;
  logic              active_s;
  logic              advance_s;

  assign active_s  = state_active(state_r);
  // A redirect is a resolved control transfer, so it pushes through a stall.
  assign advance_s = active_s & i_enable & (~i_stall | i_redirect);
  assign pc_seq_s  = pc_s + PC_INC_V;

  // Next-PC mux: redirect target taken verbatim, otherwise sequential.
  always_comb begin
    pc_load_s = pc_seq_s;
    if (i_redirect) begin
      pc_load_s = i_target;
    end else begin
      pc_load_s = pc_seq_s;
    end
  end

  pc_reg #(
    .PC_SZ    (PC_SZ),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (i_clk),
    .reset (i_reset),
    .load  (advance_s),
    .d     (pc_load_s),
    .q     (pc_s)
  );

  // Debug FSM next-state: halt only heeded in RUN, step/resume only in HALTED.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (i_halt) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_HALTED: begin
        if (i_resume) begin
          state_next_s = ST_RUN;
        end else if (i_step) begin
          state_next_s = ST_STEP;
        end else begin
          state_next_s = ST_HALTED;
        end
      end
      ST_STEP: begin
        if (advance_s) begin
          state_next_s = ST_HALTED;
        end else begin
          state_next_s = ST_STEP;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // State register plus a registered HALTED decode for o_halted.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      halted_r <= (state_next_s == ST_HALTED);
    end
  end

  // Count every PC advance; the counter wraps silently.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_r <= '0;
    end else if (advance_s) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign o_pc        = pc_s;
  assign o_pc_next   = pc_seq_s;
  assign o_valid     = active_s & i_enable & ~i_stall;
  assign o_halted    = halted_r;
  assign o_fetch_cnt = cnt_r;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus a randomized run,
// all compared against a behavioural model of the fetch/debug rules.
module tb_pc_ctrl;

  logic        clk = 1'b0;
  logic        reset, en, stall, redir, halt, step, resume;
  logic [31:0] target;
  logic [31:0] pc, pc_next, cnt;
  logic        valid, halted;

  logic        b_reset, b_en, b_stall, b_redir, b_halt, b_step, b_resume;
  logic [7:0]  b_target, b_pc, b_pc_next, b_cnt;
  logic        b_valid, b_halted;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: mode 0 = running, 1 = halted, 2 = single-stepping.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  pc_ctrl dut (
    .i_clk(clk), .i_reset(reset), .i_enable(en), .i_stall(stall),
    .i_redirect(redir), .i_target(target), .i_halt(halt), .i_step(step),
    .i_resume(resume), .o_pc(pc), .o_pc_next(pc_next), .o_valid(valid),
    .o_halted(halted), .o_fetch_cnt(cnt)
  );

  pc_ctrl #(.PC_SZ(8), .PC_INC(4), .RESET_PC(8'h00), .CNT_SZ(8)) dut8 (
    .i_clk(clk), .i_reset(b_reset), .i_enable(b_en), .i_stall(b_stall),
    .i_redirect(b_redir), .i_target(b_target), .i_halt(b_halt), .i_step(b_step),
    .i_resume(b_resume), .o_pc(b_pc), .o_pc_next(b_pc_next), .o_valid(b_valid),
    .o_halted(b_halted), .o_fetch_cnt(b_cnt)
  );

  function automatic logic m_valid();
    return (m_mode != 1) && en && !stall;
  endfunction

  // Apply one clock edge of the behavioural rules to the model.
  task automatic model_update();
    logic adv;
    if (reset) begin
      m_pc = 32'h0; m_mode = 0; m_cnt = 32'h0;
    end else begin
      adv = (m_mode != 1) && en && (!stall || redir);
      if (adv) begin
        m_pc  = redir ? target : m_pc + 32'd4;
        m_cnt = m_cnt + 32'd1;
      end
      if (m_mode == 0 && halt) m_mode = 1;
      else if (m_mode == 1 && resume) m_mode = 0;
      else if (m_mode == 1 && step) m_mode = 2;
      else if (m_mode == 2 && adv) m_mode = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; en = 1'b0; stall = 1'b0; redir = 1'b0;
    halt = 1'b0; step = 1'b0; resume = 1'b0; target = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs(); stall = 1'b1; step = 1'b1; redir = 1'b1; target = 32'h55;
    reset = 1'b1; tick(); idle_inputs(); #1;
    n_checks++; if (pc !== 32'h0) $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); else n_pass++;
    n_checks++; if (pc_next !== 32'h4) $display("FAIL reset_pc_next got=%h want=%h", pc_next, 32'h4); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted got=%b want=0", halted); else n_pass++;
    n_checks++; if (cnt !== 32'h0) $display("FAIL reset_cnt got=%0d want=0", cnt); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid_noen got=%b want=0", valid); else n_pass++;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset(); en = 1'b1; #1;
    n_checks++; if (valid !== 1'b1) $display("FAIL seq_valid got=%b want=1", valid); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'(i * 4);
      n_checks++; if (pc !== exp_pc) $display("FAIL seq_pc%0d got=%h want=%h", i, pc, exp_pc); else n_pass++;
    end
    n_checks++; if (cnt !== 32'd3) $display("FAIL seq_cnt got=%0d want=3", cnt); else n_pass++;
  endtask

  task automatic test_stall_redirect();
    do_reset(); en = 1'b1; tick(); tick();
    stall = 1'b1; #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL stall_valid got=%b want=0", valid); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (pc !== 32'h8) $display("FAIL stall_hold%0d got=%h want=%h", i, pc, 32'h8); else n_pass++;
    end
    redir = 1'b1; target = 32'h40; #1;
    n_checks++; if (valid !== 1'b0) $display("FAIL stall_redir_valid got=%b want=0", valid); else n_pass++;
    tick();
    n_checks++; if (pc !== 32'h40) $display("FAIL redir_pc got=%h want=%h", pc, 32'h40); else n_pass++;
    n_checks++; if (cnt !== 32'd3) $display("FAIL redir_cnt got=%0d want=3", cnt); else n_pass++;
  endtask

  task automatic test_halt_step();
    do_reset(); en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    halt = 1'b1; tick(); halt = 1'b0;
    n_checks++; if (pc !== 32'h14) $display("FAIL halt_pc got=%h want=%h", pc, 32'h14); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_flag got=%b want=1", halted); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL halt_valid got=%b want=0", valid); else n_pass++;
    halt = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    halt = 1'b0;
    n_checks++; if (pc !== 32'h14) $display("FAIL halt_idle_pc got=%h want=%h", pc, 32'h14); else n_pass++;
    step = 1'b1; tick(); step = 1'b0;
    n_checks++; if (halted !== 1'b0) $display("FAIL step_enter got=%b want=0", halted); else n_pass++;
    tick();
    n_checks++; if (pc !== 32'h18) $display("FAIL step_pc got=%h want=%h", pc, 32'h18); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL step_back got=%b want=1", halted); else n_pass++;
    tick();
    n_checks++; if (pc !== 32'h18) $display("FAIL step_once got=%h want=%h", pc, 32'h18); else n_pass++;
    resume = 1'b1; tick(); resume = 1'b0; tick();
    n_checks++; if (halted !== 1'b0 || pc !== 32'h1c) $display("FAIL resume_run got=%b/%h want=0/%h", halted, pc, 32'h1c); else n_pass++;
  endtask

  task automatic test_reset_in_step();
    do_reset(); en = 1'b1; tick();
    halt = 1'b1; tick(); halt = 1'b0;
    step = 1'b1; tick(); step = 1'b0; stall = 1'b1; tick();
    n_checks++; if (halted !== 1'b0 || pc !== 32'h8) $display("FAIL step_blocked got=%b/%h want=0/%h", halted, pc, 32'h8); else n_pass++;
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (pc !== 32'h0) $display("FAIL rst_step_pc got=%h want=0", pc); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL rst_step_halted got=%b want=0", halted); else n_pass++;
    n_checks++; if (cnt !== 32'h0) $display("FAIL rst_step_cnt got=%0d want=0", cnt); else n_pass++;
    stall = 1'b0;
  endtask

  task automatic test_step_resume();
    do_reset(); en = 1'b1; halt = 1'b1; tick(); halt = 1'b0;
    step = 1'b1; resume = 1'b1; tick(); step = 1'b0; resume = 1'b0;
    tick(); tick();
    n_checks++; if (halted !== 1'b0 || pc !== 32'hc) $display("FAIL step_resume got=%b/%h want=0/%h", halted, pc, 32'hc); else n_pass++;
  endtask

  task automatic test_wrap8();
    b_reset = 1'b1; b_en = 1'b0; b_stall = 1'b0; b_redir = 1'b0;
    b_halt = 1'b0; b_step = 1'b0; b_resume = 1'b0; b_target = 8'h0;
    tick(); b_reset = 1'b0; b_en = 1'b1; b_redir = 1'b1; b_target = 8'hFC; tick();
    b_redir = 1'b0;
    n_checks++; if (b_pc !== 8'hFC || b_pc_next !== 8'h00) $display("FAIL wrap_pre got=%h/%h want=fc/00", b_pc, b_pc_next); else n_pass++;
    tick();
    n_checks++; if (b_pc !== 8'h00) $display("FAIL wrap_pc got=%h want=00", b_pc); else n_pass++;
    b_en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 59) == 0);
      en     = ($urandom_range(0, 9) < 8);
      stall  = ($urandom_range(0, 9) < 3);
      redir  = ($urandom_range(0, 9) < 2);
      halt   = ($urandom_range(0, 9) == 0);
      step   = ($urandom_range(0, 9) < 2);
      resume = ($urandom_range(0, 9) < 2);
      target = $urandom;
      #1;
      n_checks++; if (valid !== m_valid()) $display("FAIL rnd_valid[%0d] got=%b want=%b", i, valid, m_valid()); else n_pass++;
      tick();
      n_checks++; if (pc !== m_pc) $display("FAIL rnd_pc[%0d] got=%h want=%h", i, pc, m_pc); else n_pass++;
      n_checks++; if (pc_next !== m_pc + 32'd4) $display("FAIL rnd_pc_next[%0d] got=%h want=%h", i, pc_next, m_pc + 32'd4); else n_pass++;
      n_checks++; if (halted !== (m_mode == 1)) $display("FAIL rnd_halted[%0d] got=%b want=%b", i, halted, (m_mode == 1)); else n_pass++;
      n_checks++; if (cnt !== m_cnt) $display("FAIL rnd_cnt[%0d] got=%0d want=%0d", i, cnt, m_cnt); else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    b_reset = 1'b1; b_en = 1'b0; b_stall = 1'b0; b_redir = 1'b0;
    b_halt = 1'b0; b_step = 1'b0; b_resume = 1'b0; b_target = 8'h0;
    m_mode = 0; m_pc = 32'h0; m_cnt = 32'h0;
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_halt_step();
    test_reset_in_step();
    test_step_resume();
    test_wrap8();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
